// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32 core: opcodes, FSM states and
// datapath select values used by the control FSM, datapath and ImmGen.
package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REGA  = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_REGB   = 2'b00,
    SRCB_IMMEXT = 2'b01,
    SRCB_FOUR   = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_e;

  typedef struct packed {
    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        i_or_d;
    alu_src_a_e  alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    result_src_e result_src;
  } ctrl_t;

  // Only beq and bne are implemented; every other funct3 falls through.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts memory wait cycles within one access and flags the cycle in which
// the WAIT_LIMIT-th consecutive not-ready cycle occurs.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // count_q holds the number of not-ready cycles already spent in this access,
  // so the current cycle is the last allowed one when it equals LAST_WAIT.
  assign timeout = enable && !ready && (count_q == LAST_WAIT);

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !ready && (count_q < LAST_WAIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment and a synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32 subset core (load/store, R/I ALU, beq/bne)
// with memory-wait timeout and illegal-opcode traps.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       Trap,
  output logic [1:0] TrapCause
);

  state_e      state_d, state_q;
  trap_cause_e cause_d, cause_q;
  ctrl_t       ctrl;
  logic        wait_en;
  logic        wait_clear;
  logic        wait_timeout;

  assign wait_en    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // Any state change restarts the count, so every access starts from zero.
  assign wait_clear = (state_d != state_q);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear),
    .enable (wait_en),
    .ready  (MemReady),
    .timeout(wait_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (wait_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_d = (Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (wait_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (wait_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I:         state_d = S_ALUWB;
      S_TRAP:                     state_d = S_TRAP;
      default:                    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = MemReady;
        ctrl.pc_write   = MemReady;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEMDATA;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_REGA;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = branch_taken(Funct3, Zero);
      end
      default: ;
    endcase
  end

  assign PCWrite   = ctrl.pc_write;
  assign IRWrite   = ctrl.ir_write;
  assign MemRead   = ctrl.mem_read;
  assign MemWrite  = ctrl.mem_write;
  assign RegWrite  = ctrl.reg_write;
  assign IorD      = ctrl.i_or_d;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ResultSrc = ctrl.result_src;
  assign Trap      = (state_q == S_TRAP);
  assign TrapCause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each scenario checks the full output
// vector cycle by cycle against hand-written per-state constants.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       Trap;
  logic [1:0] TrapCause;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control #(.WAIT_LIMIT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .Opcode   (Opcode),
    .Funct3   (Funct3),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .IorD     (IorD),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ResultSrc(ResultSrc),
    .Trap     (Trap),
    .TrapCause(TrapCause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,IRWrite,MemRead,MemWrite,RegWrite,IorD,SrcA,SrcB,ALUOp,ResultSrc,Trap,TrapCause}
  logic [16:0] outs;
  assign outs = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD,
                 ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Trap, TrapCause};

  localparam logic [16:0] O_FETCH    = 17'b0_0_1_0_0_0_00_10_00_10_0_00;
  localparam logic [16:0] O_FETCH_R  = 17'b1_1_1_0_0_0_00_10_00_10_0_00;
  localparam logic [16:0] O_DECODE   = 17'b0_0_0_0_0_0_01_01_00_00_0_00;
  localparam logic [16:0] O_MEMADR   = 17'b0_0_0_0_0_0_10_01_00_00_0_00;
  localparam logic [16:0] O_MEMREAD  = 17'b0_0_1_0_0_1_00_00_00_00_0_00;
  localparam logic [16:0] O_MEMWB    = 17'b0_0_0_0_1_0_00_00_00_01_0_00;
  localparam logic [16:0] O_MEMWR    = 17'b0_0_0_1_0_1_00_00_00_00_0_00;
  localparam logic [16:0] O_EXEC_R   = 17'b0_0_0_0_0_0_10_00_10_00_0_00;
  localparam logic [16:0] O_EXEC_I   = 17'b0_0_0_0_0_0_10_01_10_00_0_00;
  localparam logic [16:0] O_ALUWB    = 17'b0_0_0_0_1_0_00_00_00_00_0_00;
  localparam logic [16:0] O_BR_NT    = 17'b0_0_0_0_0_0_10_00_01_00_0_00;
  localparam logic [16:0] O_BR_T     = 17'b1_0_0_0_0_0_10_00_01_00_0_00;
  localparam logic [16:0] O_TRAP_ILL = 17'b0_0_0_0_0_0_00_00_00_00_1_01;
  localparam logic [16:0] O_TRAP_TO  = 17'b0_0_0_0_0_0_00_00_00_00_1_10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    MemReady = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (outs !== O_FETCH) $display("FAIL reset_state: got %b expected %b", outs, O_FETCH);
    else n_pass++;
    tick();
  endtask

  task automatic test_load();
    logic [16:0] exp_q[$];
    apply_reset();
    Opcode = OP_LOAD;
    exp_q = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMREAD, O_MEMWB, O_FETCH_R};
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_q[i]) $display("FAIL load[%0d]: got %b expected %b", i, outs, exp_q[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_store();
    logic [16:0] exp_q[$];
    apply_reset();
    Opcode = OP_STORE;
    exp_q = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMWR, O_FETCH_R};
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_q[i]) $display("FAIL store[%0d]: got %b expected %b", i, outs, exp_q[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_alu();
    logic [16:0] exp_q[$];
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      Opcode = (k == 0) ? OP_RTYPE : OP_ITYPE;
      exp_q = '{O_FETCH_R, O_DECODE, (k == 0) ? O_EXEC_R : O_EXEC_I, O_ALUWB, O_FETCH_R};
      for (int i = 0; i < exp_q.size(); i++) begin
        MemReady = 1'b1;
        #1;
        n_checks++;
        if (outs !== exp_q[i])
          $display("FAIL alu%0d[%0d]: got %b expected %b", k, i, outs, exp_q[i]);
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3_v  [6] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b111};
    logic        z_v   [6] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
    logic [16:0] br_v  [6] = '{O_BR_T, O_BR_NT, O_BR_T, O_BR_NT, O_BR_NT, O_BR_NT};
    logic [16:0] exp_q[$];
    for (int k = 0; k < 6; k++) begin
      apply_reset();
      Opcode = OP_BRANCH;
      Funct3 = f3_v[k];
      Zero   = z_v[k];
      exp_q  = '{O_FETCH_R, O_DECODE, br_v[k], O_FETCH_R};
      for (int i = 0; i < exp_q.size(); i++) begin
        MemReady = 1'b1;
        #1;
        n_checks++;
        if (outs !== exp_q[i])
          $display("FAIL branch%0d[%0d]: got %b expected %b", k, i, outs, exp_q[i]);
        else n_pass++;
        tick();
      end
    end
    Zero = 1'b0;
    Funct3 = 3'b000;
  endtask

  task automatic test_store_timeout();
    logic [16:0] exp_q[$];
    logic        rdy_q[$];
    apply_reset();
    Opcode = OP_STORE;
    exp_q = '{O_FETCH_R, O_DECODE, O_MEMADR};
    rdy_q = '{1'b1, 1'b1, 1'b1};
    repeat (15) begin exp_q.push_back(O_MEMWR);   rdy_q.push_back(1'b0); end
    repeat (3)  begin exp_q.push_back(O_TRAP_TO); rdy_q.push_back(1'b1); end
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady = rdy_q[i];
      #1;
      n_checks++;
      if (outs !== exp_q[i]) $display("FAIL store_timeout[%0d]: got %b expected %b", i, outs, exp_q[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp_q[$];
    apply_reset();
    Opcode = OP_BAD;
    exp_q = '{O_FETCH_R, O_DECODE, O_TRAP_ILL, O_TRAP_ILL};
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady = 1'b1;
      #1;
      n_checks++;
      if (outs !== exp_q[i]) $display("FAIL illegal[%0d]: got %b expected %b", i, outs, exp_q[i]);
      else n_pass++;
      tick();
    end
    apply_reset();
    #1;
    n_checks++;
    if (outs !== O_FETCH) $display("FAIL reset_from_trap: got %b expected %b", outs, O_FETCH);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [16:0] exp_q[$];
    logic        rdy_q[$];
    apply_reset();
    Opcode = OP_LOAD;
    exp_q = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMREAD, O_MEMREAD, O_MEMREAD,
              O_FETCH, O_FETCH, O_FETCH};
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady = rdy_q[i];
      reset    = (i == 5);
      #1;
      n_checks++;
      if (outs !== exp_q[i]) $display("FAIL reset_mid[%0d]: got %b expected %b", i, outs, exp_q[i]);
      else n_pass++;
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_wait();
    logic [16:0] exp_q[$];
    logic        rdy_q[$];
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      Opcode = OP_RTYPE;
      exp_q.delete();
      rdy_q.delete();
      repeat (14) begin exp_q.push_back(O_FETCH); rdy_q.push_back(1'b0); end
      if (k == 0) begin
        // Ready on the last permitted wait cycle must beat the timeout.
        exp_q.push_back(O_FETCH_R); rdy_q.push_back(1'b1);
        exp_q.push_back(O_DECODE);  rdy_q.push_back(1'b0);
        exp_q.push_back(O_EXEC_R);  rdy_q.push_back(1'b0);
      end else begin
        exp_q.push_back(O_FETCH);   rdy_q.push_back(1'b0);
        exp_q.push_back(O_TRAP_TO); rdy_q.push_back(1'b0);
        exp_q.push_back(O_TRAP_TO); rdy_q.push_back(1'b1);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        MemReady = rdy_q[i];
        #1;
        n_checks++;
        if (outs !== exp_q[i])
          $display("FAIL fetch_wait%0d[%0d]: got %b expected %b", k, i, outs, exp_q[i]);
        else n_pass++;
        tick();
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    Opcode   = 7'b0;
    Funct3   = 3'b0;
    Zero     = 1'b0;
    MemReady = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_alu();
    test_branch();
    test_store_timeout();
    test_illegal();
    test_reset_mid_access();
    test_fetch_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
